// File: rtl/ll_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ll_pkg : command ops, error codes, FSM states and sizes shared by the
//          linked-list request/response controller.   Rev 1.0
// ----------------------------------------------------------------------------
package ll_pkg;

  localparam int LL_DATA_DEPTH = 16;
  localparam int LL_PTR_WD     = 5;
  localparam int LL_WR_DATA_WD = 8;
  localparam int LL_RD_DATA_WD = 8;
  localparam int LL_TMO_CYC    = 15;

  typedef enum logic [2:0] {
    OP_APPEND = 3'b000,
    OP_INSERT = 3'b001,
    OP_READ   = 3'b010,
    OP_DELETE = 3'b011,
    OP_CLEAR  = 3'b100
  } ll_op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_FULL  = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_TMO   = 2'd3
  } ll_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ll_state_e;

  // Writes complete on wr_done; every other op completes on rd_data_out_vld.
  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_APPEND) || (op == OP_INSERT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ll_tmo_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ll_tmo_cnt : saturating WAIT-cycle counter; flags the last permitted cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
module ll_tmo_cnt #(
  parameter int TMO_CYC = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int                CNT_WD   = $clog2(TMO_CYC + 1);
  localparam logic [CNT_WD-1:0] CNT_MAX  = CNT_WD'(TMO_CYC);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TMO_CYC - 1);

  logic [CNT_WD-1:0] cnt_q;
  logic [CNT_WD-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed.
  assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/ll_req_resp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ll_req_resp_ctrl : host command/response front end for a linked-list
//                    next-pointer store, one command in flight.   Rev 1.0
// ----------------------------------------------------------------------------
module ll_req_resp_ctrl
  import ll_pkg::*;
#(
  parameter int DATA_DEPTH = LL_DATA_DEPTH,
  parameter int PTR_WD     = LL_PTR_WD,
  parameter int WR_DATA_WD = LL_WR_DATA_WD,
  parameter int RD_DATA_WD = LL_RD_DATA_WD,
  parameter int TMO_CYC    = LL_TMO_CYC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [2:0]            cmd_op,
  input  logic [PTR_WD-1:0]     cmd_pos,
  input  logic [WR_DATA_WD-1:0] cmd_data,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [RD_DATA_WD-1:0] rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  wr_vld,
  output logic                  wr_insert,
  output logic [PTR_WD-1:0]     wr_pos,
  output logic [WR_DATA_WD-1:0] wr_data_nxt_ptr,
  output logic                  rd_vld,
  output logic                  rd_delete,
  output logic [PTR_WD-1:0]     rd_addr,
  output logic                  make_ll_empty,
  input  logic                  wr_done,
  input  logic [RD_DATA_WD-1:0] rd_data,
  input  logic                  rd_data_out_vld,
  input  logic                  ll_empty,
  input  logic [PTR_WD-1:0]     ll_size
);

  localparam logic [PTR_WD-1:0] DEPTH_FULL = PTR_WD'(DATA_DEPTH);

  ll_state_e             state_q;
  ll_state_e             state_d;
  logic [2:0]            op_q;
  logic [PTR_WD-1:0]     pos_q;
  logic [WR_DATA_WD-1:0] data_q;
  logic [RD_DATA_WD-1:0] rsp_data_q;
  logic [RD_DATA_WD-1:0] rsp_data_d;
  ll_err_e               rsp_err_q;
  ll_err_e               rsp_err_d;
  logic                  live_q;
  ll_err_e               acc_err;
  logic                  accept;
  logic                  done;
  logic                  tmo_expired;

  assign accept = cmd_vld && cmd_rdy;
  assign done   = op_is_write(op_q) ? wr_done : rd_data_out_vld;

  // FULL takes precedence over RANGE for INSERT on a full list.
  always_comb begin
    acc_err = ERR_OK;
    case (cmd_op)
      OP_APPEND: if (ll_size == DEPTH_FULL) acc_err = ERR_FULL;
      OP_INSERT: begin
        if (ll_size == DEPTH_FULL)  acc_err = ERR_FULL;
        else if (cmd_pos > ll_size) acc_err = ERR_RANGE;
      end
      OP_READ, OP_DELETE: if (ll_empty || (cmd_pos >= ll_size)) acc_err = ERR_RANGE;
      OP_CLEAR: acc_err = ERR_OK;
      default:  acc_err = ERR_TMO;
    endcase
  end

  ll_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (state_q == ST_ISSUE),
    .en_i      (state_q == ST_WAIT),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (acc_err == ERR_OK) ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done || tmo_expired) state_d = ST_RESP;
      ST_RESP:  if (rsp_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy         = 1'b0;
    rsp_vld         = 1'b0;
    wr_vld          = 1'b0;
    wr_insert       = 1'b0;
    wr_pos          = '0;
    wr_data_nxt_ptr = '0;
    rd_vld          = 1'b0;
    rd_delete       = 1'b0;
    rd_addr         = '0;
    make_ll_empty   = 1'b0;
    case (state_q)
      ST_IDLE:  cmd_rdy = live_q;
      ST_ISSUE: begin
        case (op_q)
          OP_APPEND: begin
            wr_vld          = 1'b1;
            wr_data_nxt_ptr = data_q;
          end
          OP_INSERT: begin
            wr_vld          = 1'b1;
            wr_insert       = 1'b1;
            wr_pos          = pos_q;
            wr_data_nxt_ptr = data_q;
          end
          OP_READ: begin
            rd_vld  = 1'b1;
            rd_addr = pos_q;
          end
          OP_DELETE: begin
            rd_vld    = 1'b1;
            rd_delete = 1'b1;
            rd_addr   = pos_q;
            wr_pos    = pos_q;
          end
          OP_CLEAR: make_ll_empty = 1'b1;
          default:  ;
        endcase
      end
      ST_RESP:  rsp_vld = 1'b1;
      default:  ;
    endcase
  end

  // Response payload is fixed on acceptance (errors) or on leaving WAIT,
  // then simply held through RESP.
  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      rsp_data_d = '0;
      rsp_err_d  = acc_err;
    end else if (state_q == ST_WAIT) begin
      if (done) begin
        rsp_data_d = rd_data;
        rsp_err_d  = ERR_OK;
      end else if (tmo_expired) begin
        rsp_data_d = '0;
        rsp_err_d  = ERR_TMO;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q     <= 1'b0;
      op_q       <= 3'b000;
      pos_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      live_q     <= 1'b1;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (accept) begin
        op_q   <= cmd_op;
        pos_q  <= cmd_pos;
        data_q <= cmd_data;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ll_req_resp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ll_req_resp_ctrl : directed bench with a transaction-level reference
//                       model and a per-cycle output comparison.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_ll_req_resp_ctrl;

  localparam int PW = 5, WW = 8, RW = 8, DEPTH = 16, TMO = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_vld = 1'b0, cmd_rdy;
  logic [2:0]    cmd_op = 3'd0;
  logic [PW-1:0] cmd_pos = '0;
  logic [WW-1:0] cmd_data = '0;
  logic          rsp_vld, rsp_rdy = 1'b1;
  logic [RW-1:0] rsp_data;
  logic [1:0]    rsp_err;
  logic          wr_vld, wr_insert, rd_vld, rd_delete, make_ll_empty;
  logic [PW-1:0] wr_pos, rd_addr;
  logic [WW-1:0] wr_data_nxt_ptr;
  logic          wr_done = 1'b0, rd_data_out_vld = 1'b0, ll_empty = 1'b1;
  logic [RW-1:0] rd_data = '0;
  logic [PW-1:0] ll_size = '0;

  always #5 clk = ~clk;

  ll_req_resp_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_pos(cmd_pos), .cmd_data(cmd_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_vld(wr_vld), .wr_insert(wr_insert), .wr_pos(wr_pos), .wr_data_nxt_ptr(wr_data_nxt_ptr),
    .rd_vld(rd_vld), .rd_delete(rd_delete), .rd_addr(rd_addr), .make_ll_empty(make_ll_empty),
    .wr_done(wr_done), .rd_data(rd_data), .rd_data_out_vld(rd_data_out_vld),
    .ll_empty(ll_empty), .ll_size(ll_size)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record, aged in cycles since acceptance.
  bit            m_live, m_busy, m_rsp;
  int            m_age;
  logic [2:0]    m_op;
  logic [PW-1:0] m_pos;
  logic [WW-1:0] m_wdata;
  logic [1:0]    m_err;
  logic [RW-1:0] m_rdata;

  function automatic logic [1:0] spec_err(input logic [2:0] op, input int pos, input int size, input bit empty);
    if (op > 3'd4) return 2'd3;
    if ((op == 3'd0 || op == 3'd1) && size == DEPTH) return 2'd1;
    if (op == 3'd1 && pos > size) return 2'd2;
    if ((op == 3'd2 || op == 3'd3) && (empty || pos >= size)) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_live = 0; m_busy = 0; m_rsp = 0; m_age = 0;
    end else begin
      if (!m_busy) begin
        if (m_live && cmd_vld) begin
          m_busy  = 1;
          m_op    = cmd_op;
          m_pos   = cmd_pos;
          m_wdata = cmd_data;
          m_err   = spec_err(cmd_op, int'(cmd_pos), int'(ll_size), ll_empty);
          m_rdata = '0;
          m_age   = 1;
          m_rsp   = (m_err != 2'd0);
        end
      end else if (m_rsp) begin
        if (rsp_rdy) begin m_busy = 0; m_rsp = 0; end
      end else if (m_age == 1) begin
        m_age = 2;
      end else begin
        if ((m_op <= 3'd1) ? wr_done : rd_data_out_vld) begin
          m_rsp = 1; m_rdata = rd_data; m_err = 2'd0;
        end else if (m_age - 1 == TMO) begin
          m_rsp = 1; m_rdata = '0; m_err = 2'd3;
        end else begin
          m_age++;
        end
      end
      m_live = 1;
    end
  end

  bit         strobe;
  logic [4:0] exp_str;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", {cmd_rdy, rsp_vld, rsp_data, rsp_err, wr_vld, wr_insert, wr_pos,
                            wr_data_nxt_ptr, rd_vld, rd_delete, rd_addr, make_ll_empty}, 64'd0);
    end else begin
      chk("cmd_rdy", cmd_rdy, m_live && !m_busy);
      chk("rsp_vld", rsp_vld, m_rsp);
      if (m_rsp) begin
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_data", rsp_data, m_rdata);
      end
      strobe  = m_busy && !m_rsp && (m_age == 1);
      exp_str = strobe ? {m_op <= 3'd1, m_op == 3'd1, m_op == 3'd2 || m_op == 3'd3,
                          m_op == 3'd3, m_op == 3'd4} : 5'd0;
      chk("strobes", {wr_vld, wr_insert, rd_vld, rd_delete, make_ll_empty}, exp_str);
      if (strobe && (m_op == 3'd1 || m_op == 3'd3)) chk("wr_pos", wr_pos, m_pos);
      if (strobe && m_op <= 3'd1) chk("wr_data", wr_data_nxt_ptr, m_wdata);
      if (strobe && (m_op == 3'd2 || m_op == 3'd3)) chk("rd_addr", rd_addr, m_pos);
    end
  end

  // Issues one command; done_at is the WAIT cycle carrying completion (0 = never).
  // Returns at posedge+1 of the response cycle (plus one cycle if rsp_rdy is high).
  task automatic run(input logic [2:0] op, input logic [PW-1:0] pos, input logic [WW-1:0] wdata,
                     input logic [PW-1:0] size, input bit empty, input int done_at,
                     input logic [RW-1:0] rval, output int strobe_cyc, output int rsp_cyc,
                     output logic [1:0] err, output logic [RW-1:0] data);
    int n;
    strobe_cyc = 0; rsp_cyc = 0; err = 'x; data = 'x;
    cmd_op = op; cmd_pos = pos; cmd_data = wdata; ll_size = size; ll_empty = empty;
    rd_data = rval; cmd_vld = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 20) begin @(posedge clk); #1; n++; end
    if (!cmd_rdy) begin chk("cmd_rdy_wait", 0, 1); cmd_vld = 1'b0; return; end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (strobe_cyc == 0 && (wr_vld || rd_vld || make_ll_empty)) strobe_cyc = c;
      if (rsp_vld) begin rsp_cyc = c; err = rsp_err; data = rsp_data; break; end
      wr_done         = (done_at != 0) && (c == done_at + 1) && (op <= 3'd1);
      rd_data_out_vld = (done_at != 0) && (c == done_at + 1) && (op > 3'd1);
      @(posedge clk); #1;
    end
    wr_done = 1'b0; rd_data_out_vld = 1'b0;
    if (rsp_cyc == 0) chk("rsp_wait", 0, 1);
    else if (rsp_rdy) begin @(posedge clk); #1; end
  endtask

  initial begin
    int sc, rc;
    logic [1:0] e;
    logic [RW-1:0] d;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_release", cmd_rdy, 1);

    wr_done = 1'b1; rd_data_out_vld = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0; rd_data_out_vld = 1'b0;
    chk("stray_done_idle", {rsp_vld, cmd_rdy}, 2'b01);

    run(3'd0, 5'd0, 8'h2A, 5'd0, 1'b1, 1, 8'h00, sc, rc, e, d);
    chk("append_strobe_cyc", sc, 1); chk("append_rsp_cyc", rc, 3); chk("append_err", e, 0);

    run(3'd2, 5'd3, 8'h00, 5'd5, 1'b0, 1, 8'h55, sc, rc, e, d);
    chk("read_rsp_cyc", rc, 3); chk("read_err", e, 0); chk("read_data", d, 8'h55);

    run(3'd1, 5'd2, 8'h11, 5'd16, 1'b0, 1, 8'h00, sc, rc, e, d);
    chk("ins_full_strobe", sc, 0); chk("ins_full_rsp_cyc", rc, 1); chk("ins_full_err", e, 1);

    run(3'd3, 5'd4, 8'h00, 5'd4, 1'b0, 1, 8'h00, sc, rc, e, d);
    chk("del_range_rsp_cyc", rc, 1); chk("del_range_err", e, 2);

    run(3'd1, 5'd5, 8'h3C, 5'd5, 1'b0, 2, 8'h00, sc, rc, e, d);
    chk("ins_edge_rsp_cyc", rc, 4); chk("ins_edge_err", e, 0);

    run(3'd1, 5'd6, 8'h3C, 5'd5, 1'b0, 1, 8'h00, sc, rc, e, d);
    chk("ins_range_err", e, 2);

    run(3'd2, 5'd0, 8'h00, 5'd3, 1'b1, 1, 8'h00, sc, rc, e, d);
    chk("read_empty_err", e, 2);

    run(3'd6, 5'd0, 8'h00, 5'd3, 1'b0, 1, 8'h00, sc, rc, e, d);
    chk("illegal_rsp_cyc", rc, 1); chk("illegal_err", e, 3);

    run(3'd2, 5'd1, 8'h00, 5'd4, 1'b0, 0, 8'hEE, sc, rc, e, d);
    chk("tmo_rsp_cyc", rc, 17); chk("tmo_err", e, 3); chk("tmo_data", d, 8'h00);

    run(3'd2, 5'd1, 8'h00, 5'd4, 1'b0, 15, 8'hC3, sc, rc, e, d);
    chk("late_done_rsp_cyc", rc, 17); chk("late_done_err", e, 0); chk("late_done_data", d, 8'hC3);

    rsp_rdy = 1'b0;
    run(3'd3, 5'd1, 8'h00, 5'd3, 1'b0, 1, 8'h9E, sc, rc, e, d);
    chk("hold_rsp_cyc", rc, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {rsp_vld, cmd_rdy, rsp_err, rsp_data}, {1'b1, 1'b0, 2'd0, 8'h9E});
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rdy", {rsp_vld, cmd_rdy}, 2'b01);

    cmd_op = 3'd2; cmd_pos = 5'd0; ll_size = 5'd2; ll_empty = 1'b0; cmd_vld = 1'b1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_in_wait", {cmd_rdy, rsp_vld, wr_vld, rd_vld, make_ll_empty, rsp_err, rsp_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(3'd4, 5'd0, 8'h00, 5'd2, 1'b0, 1, 8'h00, sc, rc, e, d);
    chk("clear_strobe_cyc", sc, 1); chk("clear_rsp_cyc", rc, 3); chk("clear_err", e, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
